// File: rtl/data_mem_responder.sv
// Purpose: MEM-stage data responder; services one load/store at a time from an internal word-addressed RAM.
// Latency: the request is accepted in cycle T and completes in DONE at T+WAIT_CYCLES+1; load data appears on mem_din from DONE onward.
// Backpressure: mem_stall is high from the accept cycle through BUSY and freezes the pipeline; rejected requests pulse mem_err and never stall.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   mem_ren, mem_wen    - load / store request (both high is treated as a store)
//   mem_addr            - byte address; must be word aligned and inside the RAM
//   mem_dout            - store data from the datapath
//   mem_din             - registered load data; holds its value until the next completed load
//   mem_stall           - pipeline freeze request (combinational)
//   mem_err             - one-cycle pulse the cycle after a rejected request
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic                  lat_load;

    logic [31:0] ram [DEPTH];

    logic                  req;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_ok;
    logic                  accept;
    logic                  req_is_load;
    logic [31:0]           hi_bits;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;

    // Request decode. Everything above the word index must be zero for the
    // address to land inside the RAM.
    assign req          = mem_ren | mem_wen;
    assign misaligned   = (mem_addr[1:0] != 2'b00);
    assign hi_bits      = mem_addr >> (ADDR_WIDTH + 2);
    assign out_of_range = (hi_bits != 32'd0);
    assign req_ok       = req && !misaligned && !out_of_range;
    assign accept       = (state == IDLE) && req_ok;
    assign req_is_load  = mem_ren && !mem_wen;
    assign req_idx      = mem_addr[ADDR_WIDTH+1:2];

    // With zero wait states the read happens in the accept cycle itself, so
    // the read port looks at the live address while IDLE and at the latched
    // copy otherwise.
    assign rd_idx = (state == IDLE) ? req_idx : lat_idx;

    // Stall covers the accept cycle and BUSY; DONE lets the pipeline advance.
    assign mem_stall = accept || (state == BUSY);

    // Store port: committed at the end of the accept cycle so a load accepted
    // the very next cycle already sees it. The RAM has no reset.
    always_ff @(posedge clk) begin
        if (!rst && accept && mem_wen) begin
            ram[req_idx] <= mem_dout;
        end
    end

    // Control FSM with registered load data and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_idx  <= '0;
            lat_load <= 1'b0;
            mem_din  <= 32'd0;
            mem_err  <= 1'b0;
        end else begin
            // One pulse per cycle a rejected request is presented in IDLE.
            mem_err <= (state == IDLE) && req && !req_ok;

            case (state)
                IDLE: begin
                    if (req_ok) begin
                        // Store data is written during the accept cycle, so
                        // only the index and access type need keeping.
                        lat_idx  <= req_idx;
                        lat_load <= req_is_load;
                        cnt      <= WAIT_CNT;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                            if (req_is_load) begin
                                mem_din <= ram[rd_idx];
                            end
                        end else begin
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                        if (lat_load) begin
                            mem_din <= ram[rd_idx];
                        end
                    end
                end

                DONE: begin
                    // Request inputs still present here belong to the access
                    // that just completed and are deliberately ignored.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: directed self-checking bench for data_mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 builds).
// Timing: inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
// Ports: all ports of both instances are driven/observed from this module.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;

    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] dout;
    logic [31:0] din;
    logic        stall;
    logic        err;

    logic        ren0;
    logic        wen0;
    logic [31:0] addr0;
    logic [31:0] dout0;
    logic [31:0] din0;
    logic        stall0;
    logic        err0;

    int n_vec;
    int n_miss;

    data_mem_responder #(
        .ADDR_WIDTH (10),
        .WAIT_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_ren  (ren),
        .mem_wen  (wen),
        .mem_addr (addr),
        .mem_dout (dout),
        .mem_din  (din),
        .mem_stall(stall),
        .mem_err  (err)
    );

    data_mem_responder #(
        .ADDR_WIDTH (10),
        .WAIT_CYCLES(0)
    ) dut0 (
        .clk      (clk),
        .rst      (rst),
        .mem_ren  (ren0),
        .mem_wen  (wen0),
        .mem_addr (addr0),
        .mem_dout (dout0),
        .mem_din  (din0),
        .mem_stall(stall0),
        .mem_err  (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Accepted access on the WAIT_CYCLES=2 instance: request held from T to
    // DONE (T+3), dropped afterwards. Checks stall 1,1,1,0, no error, and
    // mem_din = prev_din until DONE, exp_din at DONE.
    task automatic access2(input string tag, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] prev_din, input logic [31:0] exp_din);
        ren  = r;
        wen  = w;
        addr = a;
        dout = d;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("%s stall c%0d", tag, i), {31'd0, stall}, (i < 3) ? 32'd1 : 32'd0);
            check($sformatf("%s err c%0d", tag, i), {31'd0, err}, 32'd0);
            check($sformatf("%s din c%0d", tag, i), din, (i < 3) ? prev_din : exp_din);
            next_cycle();
        end
        ren = 1'b0;
        wen = 1'b0;
    endtask

    // Rejected load held for 'hold' cycles: stall never rises, err pulses in
    // each of the following 'hold' cycles, then drops; mem_din untouched.
    task automatic reject2(input string tag, input logic [31:0] a, input int hold,
                           input logic [31:0] keep_din);
        ren  = 1'b1;
        wen  = 1'b0;
        addr = a;
        for (int i = 0; i < hold + 2; i++) begin
            @(negedge clk);
            check($sformatf("%s stall c%0d", tag, i), {31'd0, stall}, 32'd0);
            check($sformatf("%s err c%0d", tag, i), {31'd0, err},
                  ((i >= 1) && (i <= hold)) ? 32'd1 : 32'd0);
            check($sformatf("%s din c%0d", tag, i), din, keep_din);
            next_cycle();
            if (i == hold - 1) ren = 1'b0;
        end
    endtask

    // Access on the WAIT_CYCLES=0 instance: stall 1 then 0 (DONE).
    task automatic access0(input string tag, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_din);
        ren0  = r;
        wen0  = w;
        addr0 = a;
        dout0 = d;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("%s stall c%0d", tag, i), {31'd0, stall0}, (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("%s err c%0d", tag, i), {31'd0, err0}, 32'd0);
            if (i == 1) check($sformatf("%s din", tag), din0, exp_din);
            next_cycle();
        end
        ren0 = 1'b0;
        wen0 = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        ren    = 1'b0;
        wen    = 1'b0;
        addr   = 32'd0;
        dout   = 32'd0;
        ren0   = 1'b0;
        wen0   = 1'b0;
        addr0  = 32'd0;
        dout0  = 32'd0;

        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset din", din, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset din0", din0, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Store then immediately load the same word.
        access2("st10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 32'd0);
        access2("ld10", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'd0, 32'hDEAD_BEEF);
        next_cycle();

        // Rejections: misaligned, out of range, and a request held two cycles.
        reject2("rej13", 32'h0000_0013, 1, 32'hDEAD_BEEF);
        reject2("rej1000", 32'h0000_1000, 1, 32'hDEAD_BEEF);
        reject2("rejheld", 32'h0000_0012, 2, 32'hDEAD_BEEF);

        // Simultaneous read+write acts as a store and leaves mem_din alone.
        access2("rw20", 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        access2("ld20", 1'b1, 1'b0, 32'h0000_0020, 32'd0, 32'hDEAD_BEEF, 32'h1234_5678);
        access2("ld10b", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'h1234_5678, 32'hDEAD_BEEF);
        access2("ld20b", 1'b1, 1'b0, 32'h0000_0020, 32'd0, 32'hDEAD_BEEF, 32'h1234_5678);

        // Reset in the middle of a load: the load is dropped, memory is kept.
        ren  = 1'b1;
        addr = 32'h0000_0010;
        @(negedge clk);
        check("rstld stall T", {31'd0, stall}, 32'd1);
        next_cycle();
        rst = 1'b1;
        ren = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rstld stall T+2", {31'd0, stall}, 32'd0);
        check("rstld din T+2", din, 32'd0);
        check("rstld err T+2", {31'd0, err}, 32'd0);
        next_cycle();
        access2("reld10", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'd0, 32'hDEAD_BEEF);

        // Zero-wait-state build: alternating store/load, one access per 2 cycles.
        access0("w0 st40", 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 32'd0);
        access0("w0 ld40", 1'b1, 1'b0, 32'h0000_0040, 32'd0, 32'hA5A5_A5A5);
        access0("w0 st40b", 1'b0, 1'b1, 32'h0000_0040, 32'h5A5A_5A5A, 32'hA5A5_A5A5);
        access0("w0 ld40b", 1'b1, 1'b0, 32'h0000_0040, 32'd0, 32'h5A5A_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end, expected completion");
        $fatal(1, "timeout");
    end

endmodule
